// File: rtl/laundromat_pkg.sv
// Shared laundromat types: wash modes, coin-acceptor states, default prices.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
// Contents:
//   mode_t      : wash mode selector (MODE1..MODE3; encoding 3 is priced as MODE1)
//   acc_state_t : coin acceptor FSM states
//   price_of()  : default price of a mode in coin units
package laundromat_pkg;

    typedef enum logic [1:0] {
        MODE1 = 2'd0,   // soak + wash + rinse + spin
        MODE2 = 2'd1,   // wash + rinse + spin
        MODE3 = 2'd2    // rinse + spin
    } mode_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        CHANGE  = 3'd2,
        PAID    = 3'd3,
        REFUND  = 3'd4
    } acc_state_t;

    localparam int PRICE_M1_DEF = 4;
    localparam int PRICE_M2_DEF = 3;
    localparam int PRICE_M3_DEF = 2;

    // Default price table; any unlisted encoding falls back to the MODE1 price.
    function automatic int price_of(mode_t m);
        case (m)
            MODE2:   return PRICE_M2_DEF;
            MODE3:   return PRICE_M3_DEF;
            default: return PRICE_M1_DEF;
        endcase
    endfunction

endpackage

// File: rtl/laundry_idle_timer.sv
// Idle-cycle counter with synchronous clear/enable and a terminal-count flag.
// Latency: expired is combinational from the count register (count == TIMEOUT-1).
// Backpressure: none; the counter holds at TIMEOUT-1 until cleared.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear      : restart count at zero (wins over enable)
//   enable     : advance count by one per cycle
//   expired    : count has reached TIMEOUT-1
module laundry_idle_timer #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    // Saturating at LAST keeps expired asserted when a rejected coin blocks the
    // refund on the expiry cycle, so the refund follows on the next idle cycle.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/laundry_coin_acceptor.sv
// Coin acceptor: accumulates credit, signals payment to the washer, returns change/refunds.
// Latency: coin accepted at edge E updates credit at E; a completing coin pulses coin_inserted after E+1.
// Backpressure: coins are rejected (coin_reject pulse) while busy, paid, cancelling or on overflow.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   coin_valid, coin_value          : coin detector pulse and its value (0 = counterfeit)
//   mode                            : selected wash mode, re-priced every cycle
//   cancel_button, machine_busy     : refund request level, washer running level
//   coin_inserted                   : one-cycle payment-complete pulse to the washer
//   credit                          : accumulated credit
//   coin_reject                     : one-cycle coin-returned pulse
//   change_valid, change_amount     : one-cycle change return (credit - price)
//   refund_valid, refund_amount     : one-cycle full-credit refund
module laundry_coin_acceptor
    import laundromat_pkg::*;
#(
    parameter int PRICE_M1 = PRICE_M1_DEF,
    parameter int PRICE_M2 = PRICE_M2_DEF,
    parameter int PRICE_M3 = PRICE_M3_DEF,
    parameter int CREDIT_W = 8,
    parameter int TIMEOUT  = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [3:0]          coin_value,
    input  logic [1:0]          mode,
    input  logic                cancel_button,
    input  logic                machine_busy,
    output logic                coin_inserted,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amount,
    output logic                refund_valid,
    output logic [CREDIT_W-1:0] refund_amount
);

    acc_state_t state, state_nxt;

    logic [CREDIT_W-1:0] price;
    logic [CREDIT_W:0]   sum;
    logic                overflow;
    logic                pay_done;
    logic                open_for_coins;
    logic                coin_accept;
    logic                expired;
    logic                busy_seen, busy_seen_nxt;

    logic                coin_inserted_nxt;
    logic [CREDIT_W-1:0] credit_nxt;
    logic                coin_reject_nxt;
    logic                change_valid_nxt;
    logic [CREDIT_W-1:0] change_amount_nxt;
    logic                refund_valid_nxt;
    logic [CREDIT_W-1:0] refund_amount_nxt;

    // Live price lookup: a mode change while collecting re-prices at once.
    always_comb begin
        case (mode)
            2'd1:    price = CREDIT_W'(PRICE_M2);
            2'd2:    price = CREDIT_W'(PRICE_M3);
            default: price = CREDIT_W'(PRICE_M1);
        endcase
    end

    // One extra bit catches a sum beyond the credit register's range.
    assign sum      = {1'b0, credit} + (CREDIT_W + 1)'(coin_value);
    assign overflow = sum[CREDIT_W];

    assign pay_done = (state == COLLECT) && (credit >= price);

    // While the payment is completing the coin is turned away, otherwise the
    // change/paid decision taken on the old credit would lose its value.
    assign open_for_coins = !machine_busy &&
                            ((state == IDLE) ||
                             ((state == COLLECT) && !cancel_button && !pay_done));

    assign coin_accept = coin_valid && (coin_value != 4'd0) && open_for_coins && !overflow;

    laundry_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   ((state != COLLECT) || coin_accept),
        .enable  (state == COLLECT),
        .expired (expired)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            busy_seen     <= 1'b0;
            coin_inserted <= 1'b0;
            credit        <= '0;
            coin_reject   <= 1'b0;
            change_valid  <= 1'b0;
            change_amount <= '0;
            refund_valid  <= 1'b0;
            refund_amount <= '0;
        end else begin
            state         <= state_nxt;
            busy_seen     <= busy_seen_nxt;
            coin_inserted <= coin_inserted_nxt;
            credit        <= credit_nxt;
            coin_reject   <= coin_reject_nxt;
            change_valid  <= change_valid_nxt;
            change_amount <= change_amount_nxt;
            refund_valid  <= refund_valid_nxt;
            refund_amount <= refund_amount_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (coin_accept) state_nxt = COLLECT;
            end
            COLLECT: begin
                if (cancel_button)              state_nxt = REFUND;
                else if (pay_done)              state_nxt = (credit > price) ? CHANGE : PAID;
                else if (expired && !coin_valid) state_nxt = REFUND;
            end
            CHANGE:  state_nxt = PAID;
            PAID: begin
                // The wash cycle is over once busy has been seen high and then drops.
                if (busy_seen && !machine_busy) state_nxt = IDLE;
            end
            REFUND:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        busy_seen_nxt     = (state_nxt == PAID) && (busy_seen || machine_busy);
        coin_inserted_nxt = pay_done && !cancel_button;
        coin_reject_nxt   = coin_valid && !coin_accept;
        change_valid_nxt  = 1'b0;
        change_amount_nxt = '0;
        refund_valid_nxt  = 1'b0;
        refund_amount_nxt = '0;
        credit_nxt        = credit;

        if (coin_accept) credit_nxt = sum[CREDIT_W-1:0];

        case (state)
            CHANGE: begin
                change_valid_nxt  = 1'b1;
                change_amount_nxt = credit - price;
                credit_nxt        = price;
            end
            PAID: begin
                if (state_nxt == IDLE) credit_nxt = '0;
            end
            REFUND: begin
                refund_valid_nxt  = 1'b1;
                refund_amount_nxt = credit;
                credit_nxt        = '0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_laundry_coin_acceptor.sv
module tb_laundry_coin_acceptor;
    import laundromat_pkg::*;

    localparam int TO = 1000;

    typedef struct {
        int          kind;   // 0 insert, 1 change, 2 refund, 3 reject
        logic [7:0]  amount;
    } ev_t;

    localparam int K_INS = 0;
    localparam int K_CHG = 1;
    localparam int K_REF = 2;
    localparam int K_REJ = 3;

    logic       clk;
    logic       reset;
    logic       coin_valid;
    logic [3:0] coin_value;
    logic [1:0] mode;
    logic       cancel_button;
    logic       machine_busy;
    logic       coin_inserted;
    logic [7:0] credit;
    logic       coin_reject;
    logic       change_valid;
    logic [7:0] change_amount;
    logic       refund_valid;
    logic [7:0] refund_amount;

    logic       s_reset;
    logic       s_coin_valid;
    logic [3:0] s_coin_value;
    logic       s_coin_inserted;
    logic [3:0] s_credit;
    logic       s_coin_reject;
    logic       s_change_valid;
    logic [3:0] s_change_amount;
    logic       s_refund_valid;
    logic [3:0] s_refund_amount;

    int  checks = 0;
    int  errors = 0;
    ev_t sb[$];

    laundry_coin_acceptor #(.TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .coin_valid    (coin_valid),
        .coin_value    (coin_value),
        .mode          (mode),
        .cancel_button (cancel_button),
        .machine_busy  (machine_busy),
        .coin_inserted (coin_inserted),
        .credit        (credit),
        .coin_reject   (coin_reject),
        .change_valid  (change_valid),
        .change_amount (change_amount),
        .refund_valid  (refund_valid),
        .refund_amount (refund_amount)
    );

    // Narrow instance: 4-bit credit, MODE1 priced at 15.
    laundry_coin_acceptor #(.PRICE_M1(15), .CREDIT_W(4), .TIMEOUT(8)) dut_small (
        .clk           (clk),
        .reset         (s_reset),
        .coin_valid    (s_coin_valid),
        .coin_value    (s_coin_value),
        .mode          (2'd0),
        .cancel_button (1'b0),
        .machine_busy  (1'b0),
        .coin_inserted (s_coin_inserted),
        .credit        (s_credit),
        .coin_reject   (s_coin_reject),
        .change_valid  (s_change_valid),
        .change_amount (s_change_amount),
        .refund_valid  (s_refund_valid),
        .refund_amount (s_refund_amount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] amount);
        ev_t e;
        e.kind   = kind;
        e.amount = amount;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input int kind, input logic [7:0] amount);
        ev_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_unexpected: observed event kind %0d amount %0d expected none", kind, amount);
        end else begin
            e = sb.pop_front();
            chk("sb_kind", kind, e.kind);
            chk("sb_amount", {24'd0, amount}, {24'd0, e.amount});
        end
    endtask

    // Output monitor: every pulse must match the next expected event.
    always @(negedge clk) begin
        if (!reset) begin
            if (coin_inserted) pop_chk(K_INS, 8'd0);
            if (change_valid)  pop_chk(K_CHG, change_amount);
            if (refund_valid)  pop_chk(K_REF, refund_amount);
            if (coin_reject)   pop_chk(K_REJ, 8'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [3:0] v);
        coin_valid = 1'b1;
        coin_value = v;
        tick();
        coin_valid = 1'b0;
        coin_value = 4'd0;
    endtask

    task automatic s_coin(input logic [3:0] v);
        s_coin_valid = 1'b1;
        s_coin_value = v;
        tick();
        s_coin_valid = 1'b0;
        s_coin_value = 4'd0;
    endtask

    initial begin
        reset = 1'b1; s_reset = 1'b1;
        coin_valid = 1'b0; coin_value = 4'd0; mode = 2'd0;
        cancel_button = 1'b0; machine_busy = 1'b0;
        s_coin_valid = 1'b0; s_coin_value = 4'd0;
        tick(); tick();
        reset = 1'b0; s_reset = 1'b0;

        // Reset state
        chk("rst_credit", credit, 0);
        chk("rst_ins", coin_inserted, 0);
        chk("rst_chg", change_valid, 0);
        chk("rst_ref", refund_valid, 0);
        chk("rst_rej", coin_reject, 0);
        chk("rst_amts", {change_amount, refund_amount}, 0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));

        // MODE1, two coins of 2 pay exactly
        mode = 2'd0;
        coin(4'd2); chk("t1_credit2", credit, 2);
        coin(4'd2); chk("t1_credit4", credit, 4);
        chk("t1_no_early_ins", coin_inserted, 0);
        push(K_INS, 8'd0);
        tick();
        chk("t1_ins", coin_inserted, 1);
        chk("t1_state_paid", 32'(dut.state), 32'(PAID));
        tick();
        chk("t1_ins_once", coin_inserted, 0);
        chk("t1_no_change", change_valid, 0);
        push(K_REJ, 8'd0);
        coin(4'd2);
        chk("t1_paid_rej", coin_reject, 1);
        chk("t1_paid_credit", credit, 4);
        machine_busy = 1'b1; tick(); tick();
        chk("t1_wait_busy", 32'(dut.state), 32'(PAID));
        machine_busy = 1'b0; tick();
        chk("t1_done_credit", credit, 0);
        chk("t1_done_state", 32'(dut.state), 32'(IDLE));

        // Rejects while washer busy and for counterfeit coins
        machine_busy = 1'b1;
        push(K_REJ, 8'd0);
        coin(4'd2);
        chk("t5_busy_credit", credit, 0);
        machine_busy = 1'b0;
        push(K_REJ, 8'd0);
        coin(4'd0);
        chk("t5_zero_credit", credit, 0);
        chk("t5_zero_state", 32'(dut.state), 32'(IDLE));

        // MODE3 overpaid with 5: change of 3
        mode = 2'd2;
        coin(4'd5); chk("t2_credit5", credit, 5);
        push(K_INS, 8'd0); push(K_CHG, 8'd3);
        tick();
        chk("t2_ins", coin_inserted, 1);
        tick();
        chk("t2_chg_amt", change_amount, 3);
        chk("t2_credit2", credit, 2);
        chk("t2_no_ref", refund_valid, 0);
        machine_busy = 1'b1; tick();
        machine_busy = 1'b0; tick();
        chk("t2_idle", 32'(dut.state), 32'(IDLE));
        chk("t2_credit0", credit, 0);

        // Cancel refund; coin arriving with cancel is rejected
        mode = 2'd0;
        coin(4'd1);
        cancel_button = 1'b1; coin_valid = 1'b1; coin_value = 4'd1;
        push(K_REJ, 8'd0);
        tick();
        cancel_button = 1'b0; coin_valid = 1'b0; coin_value = 4'd0;
        chk("t3_credit_held", credit, 1);
        push(K_REF, 8'd1);
        tick();
        chk("t3_ref_amt", refund_amount, 1);
        chk("t3_credit0", credit, 0);
        chk("t3_idle", 32'(dut.state), 32'(IDLE));

        // Inactivity refund after TIMEOUT idle cycles
        coin(4'd1);
        for (int i = 0; i < TO - 1; i++) tick();
        chk("t4_not_early", 32'(dut.state), 32'(COLLECT));
        push(K_REF, 8'd1);
        tick(); tick();
        chk("t4_ref_amt", refund_amount, 1);
        chk("t4_credit0", credit, 0);

        // Coin on the expiry cycle wins and restarts the timer
        coin(4'd1);
        for (int i = 0; i < TO - 1; i++) tick();
        coin(4'd1);
        chk("t4b_credit2", credit, 2);
        chk("t4b_collect", 32'(dut.state), 32'(COLLECT));
        for (int i = 0; i < TO - 1; i++) tick();
        chk("t4b_restart", 32'(dut.state), 32'(COLLECT));
        chk("t4b_no_ref", refund_valid, 0);
        push(K_REF, 8'd2);
        tick(); tick();
        chk("t4b_ref_amt", refund_amount, 2);

        // Narrow instance: overflow reject, exact max, reset mid-collect
        s_coin(4'd7); s_coin(4'd7);
        chk("t6_credit14", s_credit, 14);
        s_coin(4'd2);
        chk("t6_ovf_rej", s_coin_reject, 1);
        chk("t6_ovf_credit", s_credit, 14);
        s_coin(4'd1);
        chk("t6_credit15", s_credit, 15);
        s_reset = 1'b1; tick(); s_reset = 1'b0;
        chk("t6_rst_credit", s_credit, 0);
        chk("t6_rst_noref", s_refund_valid, 0);
        tick();
        chk("t6_rst_noref2", s_refund_valid, 0);
        chk("t6_rst_noins", s_coin_inserted, 0);
        chk("t6_rst_quiet", {s_change_valid, s_change_amount, s_refund_amount}, 0);

        tick(); tick();
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
